// File: rtl/bfs_pkg.sv
// Shared constants for the BFS occupancy-word run controller and its writeback FIFO.
// Holds the state encoding, the word width, error codes and a start-acceptance helper.
package bfs_pkg;

  localparam int OCC_WORD_W = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  // Any state outside the active run phases accepts a start, so unused encodings recover too.
  function automatic logic st_accepts_start(input logic [2:0] s);
    return !((s == ST_CLR) || (s == ST_RUN) || (s == ST_DRAIN));
  endfunction

endpackage

// File: rtl/bfs_occ_fifo.sv
// First-word-fall-through FIFO: head visible on o_dat one cycle after the push that fills an empty FIFO.
// Push while full is accepted only together with a pop; flush wins over push and pop.
module bfs_occ_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = i_pop && !o_empty;
    do_push  = i_push && (!o_full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_dat;
  end

  assign o_dat   = mem_q[rd_ptr_q];
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/bfs_occ_ctrl.sv
// BFS core run controller: soft reset/enable, send-edge capture into a FIFO, DDR writeback at 8-byte strides.
// Captured word is offered one cycle later; DDR stalls hold addr/data, a capture into a full unpopped FIFO is an error.
module bfs_occ_ctrl
  import bfs_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32,
  parameter int CLR_CYCLES = 2,
  parameter int TMO_W      = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic [TMO_W-1:0]      i_timeout,
  output logic                  o_bfs_rst_n,
  output logic                  o_bfs_en,
  input  logic                  i_bfs_finish,
  input  logic [OCC_WORD_W-1:0] i_occ_word,
  input  logic                  i_occ_send,
  output logic                  o_wr_valid,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [OCC_WORD_W-1:0] o_wr_data,
  output logic                  o_wr_last,
  input  logic                  i_wr_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic [15:0]           o_words
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  logic [2:0]        state_q, state_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              send_q, send_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  logic [1:0]        err_code_q, err_code_d;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [OCC_WORD_W-1:0] fifo_dat;

  logic wr_vld, xfer, cap, ovf, tmo, can_start;

  always_comb begin
    wr_vld     = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !fifo_empty;
    xfer       = wr_vld && i_wr_ready;
    cap        = (state_q == ST_RUN) && i_occ_send && !send_q;
    // A pop in the same cycle frees the slot, so only an unpopped full FIFO overflows.
    ovf        = cap && fifo_full && !xfer;
    tmo        = (state_q == ST_RUN) && !cap && (i_timeout != '0) &&
                 ((wdog_q + TMO_W'(1)) == i_timeout);
    can_start  = i_start && st_accepts_start(state_q);
    fifo_push  = cap && !ovf;
    fifo_pop   = xfer;
    fifo_flush = can_start || ovf || tmo;
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wdog_d     = wdog_q;
    addr_d     = addr_q;
    words_d    = words_q;
    err_code_d = err_code_q;
    send_d     = i_occ_send;

    if (xfer) begin
      addr_d = addr_q + ADDR_W'(8);
      if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
    end

    case (state_q)
      ST_CLR: begin
        if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = ST_RUN;
          wdog_d  = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      ST_RUN: begin
        wdog_d = cap ? '0 : (wdog_q + TMO_W'(1));
        if (ovf) begin
          state_d    = ST_ERR;
          err_code_d = ERR_OVF;
        end else if (tmo) begin
          state_d    = ST_ERR;
          err_code_d = ERR_TMO;
        end else if (i_bfs_finish) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty || (xfer && (fifo_count == CW'(1)))) state_d = ST_DONE;
      end
      default: begin
        if (can_start) begin
          state_d    = ST_CLR;
          clr_cnt_d  = '0;
          words_d    = '0;
          err_code_d = ERR_NONE;
          addr_d     = i_base_addr & ~ADDR_W'(7);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      send_q     <= 1'b0;
      wdog_q     <= '0;
      addr_q     <= '0;
      words_q    <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      send_q     <= send_d;
      wdog_q     <= wdog_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      err_code_q <= err_code_d;
    end
  end

  bfs_occ_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OCC_WORD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_dat   (i_occ_word),
    .i_pop   (fifo_pop),
    .i_flush (fifo_flush),
    .o_dat   (fifo_dat),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_bfs_rst_n = (state_q != ST_CLR);
  assign o_bfs_en    = (state_q == ST_RUN);
  assign o_wr_valid  = wr_vld;
  assign o_wr_addr   = addr_q;
  assign o_wr_data   = wr_vld ? fifo_dat : '0;
  assign o_wr_last   = (state_q == ST_DRAIN) && (fifo_count == CW'(1));
  assign o_busy      = (state_q == ST_CLR) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = (state_q == ST_ERR);
  assign o_err_code  = err_code_q;
  assign o_words     = words_q;

endmodule

// File: tb/tb_bfs_occ_ctrl.sv
// Bench for bfs_occ_ctrl: directed scenarios plus randomized runs against a queue-based run model.
module tb_bfs_occ_ctrl;

  localparam int FIFO_DEPTH = 8;
  localparam int CLR_CYCLES = 2;

  localparam int M_IDLE = 0, M_CLR = 1, M_RUN = 2, M_DRAIN = 3, M_DONE = 4, M_ERR = 5;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_base_addr = '0;
  logic [23:0] i_timeout = '0;
  logic        o_bfs_rst_n, o_bfs_en;
  logic        i_bfs_finish = 1'b0;
  logic [63:0] i_occ_word = '0;
  logic        i_occ_send = 1'b0;
  logic        o_wr_valid;
  logic [31:0] o_wr_addr;
  logic [63:0] o_wr_data;
  logic        o_wr_last;
  logic        i_wr_ready = 1'b0;
  logic        o_busy, o_done, o_err;
  logic [1:0]  o_err_code;
  logic [15:0] o_words;

  bfs_occ_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (32),
    .CLR_CYCLES (CLR_CYCLES),
    .TMO_W      (24)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_timeout    (i_timeout),
    .o_bfs_rst_n  (o_bfs_rst_n),
    .o_bfs_en     (o_bfs_en),
    .i_bfs_finish (i_bfs_finish),
    .i_occ_word   (i_occ_word),
    .i_occ_send   (i_occ_send),
    .o_wr_valid   (o_wr_valid),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_wr_last    (o_wr_last),
    .i_wr_ready   (i_wr_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_words      (o_words)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Run model: phase, word queue, write pointer and counters.
  int          m_ph = M_IDLE;
  logic [63:0] m_q[$];
  logic [31:0] m_addr = '0;
  int          m_words = 0;
  int          m_code = 0;
  int          m_clr = 0;
  int          m_wd = 0;
  logic        m_prev = 1'b0;
  bit          mv_vld, mv_xfer, mv_cap;

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      m_ph = M_IDLE; m_q.delete(); m_addr = '0; m_words = 0; m_code = 0; m_prev = 1'b0;
    end else begin
      mv_vld  = ((m_ph == M_RUN) || (m_ph == M_DRAIN)) && (m_q.size() > 0);
      mv_xfer = mv_vld && i_wr_ready;
      mv_cap  = (m_ph == M_RUN) && i_occ_send && !m_prev;
      if (mv_xfer) begin
        void'(m_q.pop_front());
        m_addr = m_addr + 32'd8;
        if (m_words < 65535) m_words++;
      end
      case (m_ph)
        M_CLR: begin
          m_clr--;
          if (m_clr == 0) begin m_ph = M_RUN; m_wd = 0; end
        end
        M_RUN: begin
          if (mv_cap) begin
            if (m_q.size() == FIFO_DEPTH) begin
              m_ph = M_ERR; m_code = 1; m_q.delete();
            end else begin
              m_q.push_back(i_occ_word); m_wd = 0;
              if (i_bfs_finish) m_ph = M_DRAIN;
            end
          end else begin
            m_wd++;
            if (i_timeout != 0 && m_wd == int'(i_timeout)) begin
              m_ph = M_ERR; m_code = 2; m_q.delete();
            end else if (i_bfs_finish) m_ph = M_DRAIN;
          end
        end
        M_DRAIN: if (m_q.size() == 0) m_ph = M_DONE;
        default: if (i_start) begin
          m_ph = M_CLR; m_clr = CLR_CYCLES; m_words = 0; m_code = 0; m_q.delete();
          m_addr = i_base_addr & 32'hFFFF_FFF8;
        end
      endcase
      m_prev = i_occ_send;
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      chk("bfs_rst_n", 64'(o_bfs_rst_n), 64'(m_ph != M_CLR));
      chk("bfs_en", 64'(o_bfs_en), 64'(m_ph == M_RUN));
      chk("wr_valid", 64'(o_wr_valid), 64'(((m_ph == M_RUN) || (m_ph == M_DRAIN)) && m_q.size() > 0));
      if (o_wr_valid && m_q.size() > 0) begin
        chk("wr_data", o_wr_data, m_q[0]);
        chk("wr_addr", 64'(o_wr_addr), 64'(m_addr));
      end
      chk("wr_last", 64'(o_wr_last), 64'((m_ph == M_DRAIN) && m_q.size() == 1));
      chk("busy", 64'(o_busy), 64'((m_ph == M_CLR) || (m_ph == M_RUN) || (m_ph == M_DRAIN)));
      chk("done", 64'(o_done), 64'(m_ph == M_DONE));
      chk("err", 64'(o_err), 64'(m_ph == M_ERR));
      chk("err_code", 64'(o_err_code), 64'(m_code));
      chk("words", 64'(o_words), 64'(m_words));
    end
  end

  // Log of accepted writes for the directed expectations.
  logic [31:0] wa[$];
  logic [63:0] wd[$];
  logic        wl[$];
  always @(negedge i_clk) begin
    if (i_rst && o_wr_valid && i_wr_ready) begin
      wa.push_back(o_wr_addr); wd.push_back(o_wr_data); wl.push_back(o_wr_last);
    end
  end

  task automatic tick;
    @(posedge i_clk); #1;
    if (rnd_rdy) i_wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_start(input logic [31:0] base, input logic [23:0] tmo);
    wa.delete(); wd.delete(); wl.delete();
    i_base_addr = base; i_timeout = tmo; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input int hold, input int gap);
    i_occ_word = w; i_occ_send = 1'b1;
    repeat (hold) tick();
    i_occ_send = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_last(input logic [63:0] w);
    i_occ_word = w; i_occ_send = 1'b1; i_bfs_finish = 1'b1;
    tick();
    i_occ_send = 1'b0; i_bfs_finish = 1'b0;
    tick();
  endtask

  task automatic finish_pulse;
    i_bfs_finish = 1'b1;
    tick();
    i_bfs_finish = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int budget);
    int k;
    k = 0;
    while (!o_done && !o_err && k < budget) begin tick(); k++; end
    n_chk++;
    if (!(o_done || o_err)) begin
      n_err++;
      $display("FAIL %s: done=%0b err=%0b after %0d cycles, required done or err", nm, o_done, o_err, budget);
    end
  endtask

  logic [63:0] ew[FIFO_DEPTH];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk_on = 1'b1;
    chk("rst_bfs_rst_n", 64'(o_bfs_rst_n), 64'd1);
    chk("rst_en", 64'(o_bfs_en), 64'd0);
    chk("rst_valid", 64'(o_wr_valid), 64'd0);
    chk("rst_addr", 64'(o_wr_addr), 64'd0);
    chk("rst_data", o_wr_data, 64'd0);
    chk("rst_busy_done_err", 64'({o_busy, o_done, o_err, o_wr_last}), 64'd0);
    chk("rst_code_words", 64'({o_err_code, o_words}), 64'd0);
    i_rst = 1'b1;
    tick();

    // Base run with start sequencing.
    i_wr_ready = 1'b1;
    do_start(32'h1000_0000, 24'd0);
    chk("clr_c1_rst_n", 64'(o_bfs_rst_n), 64'd0);
    chk("clr_c1_en", 64'(o_bfs_en), 64'd0);
    tick();
    chk("clr_c2_rst_n", 64'(o_bfs_rst_n), 64'd0);
    tick();
    chk("run_rst_n", 64'(o_bfs_rst_n), 64'd1);
    chk("run_en", 64'(o_bfs_en), 64'd1);
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("restart_ignored_en", 64'(o_bfs_en), 64'd1);
    send_word(64'hAAAA_0000_0000_0001, 1, 2);
    send_word(64'hBBBB_0000_0000_0002, 1, 2);
    send_last(64'hCCCC_0000_0000_0003);
    wait_end("base_end", 50);
    chk("base_nwrites", 64'(wa.size()), 64'd3);
    if (wa.size() == 3) begin
      chk("base_addr0", 64'(wa[0]), 64'h1000_0000);
      chk("base_addr1", 64'(wa[1]), 64'h1000_0008);
      chk("base_addr2", 64'(wa[2]), 64'h1000_0010);
      chk("base_data0", wd[0], 64'hAAAA_0000_0000_0001);
      chk("base_data2", wd[2], 64'hCCCC_0000_0000_0003);
      chk("base_last", 64'({wl[0], wl[1], wl[2]}), 64'b001);
    end
    chk("base_words", 64'(o_words), 64'd3);
    chk("base_done", 64'(o_done), 64'd1);

    // Held send counts once; start from DONE clears the word count.
    do_start(32'h0000_4000, 24'd0);
    chk("start_clears_words", 64'(o_words), 64'd0);
    repeat (2) tick();
    send_word(64'h1234_5678_9ABC_DEF0, 4, 3);
    finish_pulse();
    wait_end("hold_end", 50);
    chk("hold_words", 64'(o_words), 64'd1);
    chk("hold_nwrites", 64'(wa.size()), 64'd1);

    // Backpressure fills the FIFO exactly; base low bits are ignored.
    i_wr_ready = 1'b0;
    do_start(32'h2000_0005, 24'd0);
    repeat (2) tick();
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      ew[i] = {$urandom, $urandom};
      send_word(ew[i], 1, 1);
    end
    repeat (3) tick();
    chk("bp_no_err", 64'(o_err), 64'd0);
    chk("bp_head", o_wr_data, ew[0]);
    finish_pulse();
    repeat (3) tick();
    i_wr_ready = 1'b1;
    wait_end("bp_end", 50);
    chk("bp_words", 64'(o_words), 64'(FIFO_DEPTH));
    chk("bp_nwrites", 64'(wa.size()), 64'(FIFO_DEPTH));
    for (int i = 0; i < wa.size() && i < FIFO_DEPTH; i++) begin
      chk("bp_addr", 64'(wa[i]), 64'(32'h2000_0000 + 32'(8 * i)));
      chk("bp_data", wd[i], ew[i]);
    end
    if (wl.size() == FIFO_DEPTH) chk("bp_last", 64'(wl[FIFO_DEPTH-1]), 64'd1);

    // Overflow on the ninth capture.
    i_wr_ready = 1'b0;
    do_start(32'h3000_0000, 24'd0);
    repeat (2) tick();
    for (int i = 0; i <= FIFO_DEPTH; i++) send_word({$urandom, $urandom}, 1, 1);
    chk("ovf_err", 64'(o_err), 64'd1);
    chk("ovf_code", 64'(o_err_code), 64'd1);
    chk("ovf_en", 64'(o_bfs_en), 64'd0);
    chk("ovf_valid", 64'(o_wr_valid), 64'd0);

    // Watchdog fires 100 RUN cycles after entry.
    i_wr_ready = 1'b1;
    do_start(32'h4000_0000, 24'd100);
    chk("tmo_cleared_err", 64'(o_err), 64'd0);
    repeat (2) tick();
    repeat (99) tick();
    chk("tmo_not_yet", 64'(o_err), 64'd0);
    tick();
    chk("tmo_err", 64'(o_err), 64'd1);
    chk("tmo_code", 64'(o_err_code), 64'd2);

    // Empty run.
    do_start(32'h5000_0000, 24'd0);
    repeat (5) tick();
    finish_pulse();
    wait_end("empty_end", 20);
    chk("empty_done", 64'(o_done), 64'd1);
    chk("empty_words", 64'(o_words), 64'd0);
    chk("empty_nwrites", 64'(wa.size()), 64'd0);

    // Randomized runs, checked cycle by cycle against the model.
    rnd_rdy = 1'b1;
    for (int r = 0; r < 24; r++) begin
      int n;
      n = $urandom_range(0, 11);
      do_start({$urandom} , (r % 4 == 3) ? 24'($urandom_range(5, 40)) : 24'd0);
      repeat (2) tick();
      for (int k = 0; k < n; k++)
        send_word({$urandom, $urandom}, $urandom_range(1, 3), $urandom_range(0, 3));
      finish_pulse();
      wait_end("rand_end", 200);
    end
    rnd_rdy = 1'b0;

    // Asynchronous reset while draining three stalled words.
    i_wr_ready = 1'b0;
    do_start(32'h6000_0000, 24'd0);
    repeat (2) tick();
    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1, 1);
    finish_pulse();
    chk("pre_rst_valid", 64'(o_wr_valid), 64'd1);
    #2;
    i_rst = 1'b0;
    #1;
    chk("arst_bfs_rst_n", 64'(o_bfs_rst_n), 64'd1);
    chk("arst_en_valid_last", 64'({o_bfs_en, o_wr_valid, o_wr_last}), 64'd0);
    chk("arst_busy_done_err", 64'({o_busy, o_done, o_err}), 64'd0);
    chk("arst_addr", 64'(o_wr_addr), 64'd0);
    chk("arst_data", o_wr_data, 64'd0);
    chk("arst_code_words", 64'({o_err_code, o_words}), 64'd0);
    i_wr_ready = 1'b1;
    tick();
    i_rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 64'(o_wr_valid), 64'd0);
    chk("post_rst_idle", 64'({o_busy, o_done, o_err}), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
